riscv_fetch: RTL



---
 rtl/riscv_fetch_pkg.sv | 15 +
 rtl/riscv_fetch_if.sv | 67 ++++++
 rtl/riscv_fetch_fifo.sv | 66 ++++++
 rtl/riscv_fetch.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro: RISCV_FETCH_MISALIGN_EXC_EN.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_ADDRESS = 32'h0000_0200;
  localparam int PC_INCREMENT = 4;

endpackage

// File: rtl/riscv_fetch_if.sv
// Instruction-memory and decode-side signals of the fetch stage.
// Macro RISCV_FETCH_MISALIGN_EXC_EN adds fetch_misaligned.
interface riscv_fetch_if #(
  parameter int INST_ADDR_WIDTH = 32,
  parameter int INST_DATA_WIDTH = 32,
  parameter int PC_WIDTH = 32
);

  logic                       imem_req;
  logic [INST_ADDR_WIDTH-1:0] imem_address;
  logic                       imem_gnt;
  logic                       imem_rvalid;
  logic [INST_DATA_WIDTH-1:0] imem_rdata;
  logic                       stall;
  logic                       branch_taken;
  logic [PC_WIDTH-1:0]        branch_target;
  logic                       exception_taken;
  logic [PC_WIDTH-1:0]        exception_target;
  logic [INST_DATA_WIDTH-1:0] inst_data;
  logic [INST_ADDR_WIDTH-1:0] inst_address;
  logic                       inst_ready;
  logic                       inst_count;
`ifdef RISCV_FETCH_MISALIGN_EXC_EN
  logic                       fetch_misaligned;
`endif

  modport master (
`ifdef RISCV_FETCH_MISALIGN_EXC_EN
    output fetch_misaligned,
`endif
    output imem_req,
    output imem_address,
    output inst_data,
    output inst_address,
    output inst_ready,
    output inst_count,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  exception_taken,
    input  exception_target
  );

  modport slave (
`ifdef RISCV_FETCH_MISALIGN_EXC_EN
    input  fetch_misaligned,
`endif
    input  imem_req,
    input  imem_address,
    input  inst_data,
    input  inst_address,
    input  inst_ready,
    input  inst_count,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output stall,
    output branch_taken,
    output branch_target,
    output exception_taken,
    output exception_target
  );

endinterface

// File: rtl/riscv_fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction word} pairs.
// Clear wins over push/pop; push while full is allowed with a pop.
module riscv_fetch_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  input  logic              clear,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = data_q[rd_ptr];
  assign head_addr = addr_q[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr] <= push_data;
        addr_q[wr_ptr] <= push_addr;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
// Fetch stage: PC, in-order imem requests, prefetch FIFO, redirects.
// Macro RISCV_FETCH_MISALIGN_EXC_EN: misaligned targets yield a NOP entry.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = 32,
  parameter int INST_DATA_WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter logic [31:0] RESET_ADDRESS = DEFAULT_RESET_ADDRESS,
  parameter int FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  riscv_fetch_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int QW = $clog2(FIFO_DEPTH);

  fetch_state_e               state_q;
  fetch_state_e               state_d;
  logic [PC_WIDTH-1:0]        pc;
  logic [PC_WIDTH-1:0]        raw_target;
  logic [PC_WIDTH-1:0]        target;
  logic [CW-1:0]              outstanding;
  logic [CW-1:0]              out_next;
  logic [CW-1:0]              occ;
  logic [CW:0]                inflight;
  logic                       redirect;
  logic                       issue;
  logic                       rsp;
  logic                       push_rsp;
  logic                       push;
  logic                       pop;
  logic                       empty;
  logic                       full;
  logic                       hold;
  logic [INST_DATA_WIDTH-1:0] push_data;
  logic [INST_ADDR_WIDTH-1:0] push_addr;
  logic [INST_DATA_WIDTH-1:0] head_data;
  logic [INST_ADDR_WIDTH-1:0] head_addr;
  logic [INST_ADDR_WIDTH-1:0] aq [FIFO_DEPTH];
  logic [QW-1:0]              aq_wr;
  logic [QW-1:0]              aq_rd;

  assign redirect   = bus.exception_taken || bus.branch_taken;
  assign raw_target = bus.exception_taken ? bus.exception_target
                                          : bus.branch_target;

`ifdef RISCV_FETCH_MISALIGN_EXC_EN
  logic nop_pend;
  logic mis_target;

  assign target     = raw_target;
  assign mis_target = (target[1:0] != 2'b00);

  // Misaligned redirect: park fetch and queue one NOP marker entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold     <= 1'b0;
      nop_pend <= 1'b0;
    end else if (redirect) begin
      hold     <= mis_target;
      nop_pend <= mis_target;
    end else if (nop_pend) begin
      nop_pend <= 1'b0;
    end
  end

  assign bus.fetch_misaligned = hold && !empty;
  assign push      = push_rsp || (nop_pend && !redirect);
  assign push_data = nop_pend ? INST_DATA_WIDTH'(NOP_INSTRUCTION)
                              : bus.imem_rdata;
  assign push_addr = nop_pend ? INST_ADDR_WIDTH'(pc) : aq[aq_rd];
`else
  assign target    = raw_target & ~PC_WIDTH'(3);
  assign hold      = 1'b0;
  assign push      = push_rsp;
  assign push_data = bus.imem_rdata;
  assign push_addr = aq[aq_rd];
`endif

  assign issue    = bus.imem_req && bus.imem_gnt;
  assign rsp      = bus.imem_rvalid && (outstanding != '0);
  assign out_next = outstanding + CW'(issue) - CW'(rsp);
  assign inflight = (CW+1)'(outstanding) + (CW+1)'(occ);
  assign push_rsp = rsp && (state_q == RUN) && !redirect && !hold
                    && (!full || pop);
  assign pop      = !empty && !bus.stall && !redirect;

  assign bus.imem_req = (state_q == RUN) && !hold
                        && (inflight < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_address = (state_q == IDLE) ? '0
                                              : INST_ADDR_WIDTH'(pc);

  assign bus.inst_ready   = !empty;
  assign bus.inst_count   = !empty;
  assign bus.inst_data    = empty ? '0 : head_data;
  assign bus.inst_address = empty ? '0 : head_addr;

  // Next state: leave RUN to drain stale responses after a redirect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (redirect && out_next != '0) state_d = DRAIN;
      DRAIN:   if (out_next == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State, PC and outstanding-request counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc          <= PC_WIDTH'(RESET_ADDRESS);
      outstanding <= '0;
    end else begin
      state_q     <= state_d;
      outstanding <= out_next;
      if (redirect) begin
        pc <= target;
      end else if (issue) begin
        pc <= pc + PC_WIDTH'(PC_INCREMENT);
      end
    end
  end

  // PCs of granted requests, consumed in order as responses return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aq_wr <= '0;
      aq_rd <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        aq[i] <= '0;
      end
    end else begin
      if (issue) begin
        aq[aq_wr] <= INST_ADDR_WIDTH'(pc);
        aq_wr     <= aq_wr + QW'(1);
      end
      if (rsp) begin
        aq_rd <= aq_rd + QW'(1);
      end
    end
  end

  riscv_fetch_fifo #(
    .DATA_W (INST_DATA_WIDTH),
    .ADDR_W (INST_ADDR_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .push_addr (push_addr),
    .pop       (pop),
    .clear     (redirect),
    .head_data (head_data),
    .head_addr (head_addr),
    .full      (full),
    .empty     (empty),
    .count     (occ)
  );

endmodule
